psram_arbiter: RTL and testbench
================================

PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, memory word/byte address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles waiting for mem_busy low before error.
REQ-004 SHALL have ports: clk  in  1  single clock for all logic; resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have, per requester n in {0,1}: pn_req  in  1  request, held high until pn_done.
REQ-006 SHALL have pn_write  in  1  1=write, 0=read; pn_byte  in  1  byte-write qualifier.
REQ-007 SHALL have pn_addr  in  ADDR_W  address; pn_wdata  in  DATA_W  write data.
REQ-008 SHALL have pn_done  out  1  one-cycle completion pulse; pn_err  out  1  timeout flag, valid with pn_done.
REQ-009 SHALL have pn_rdata  out  DATA_W  read data, valid with pn_done and held until next read completion on that port.
REQ-010 SHALL have memory side: mem_read, mem_write, mem_byte_write  out  1; mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W; mem_busy  in  1.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, GUARD, WAIT, RESP.
REQ-012 IDLE SHALL grant only when mem_busy=0 and at least one pn_req=1; grant latches port id, write, byte, addr, wdata into registers; next state ISSUE.
REQ-013 ISSUE SHALL drive mem_read or mem_write high for exactly one cycle with registered addr/din/byte_write; next state GUARD.
REQ-014 GUARD SHALL last exactly one cycle, ignoring mem_busy; next state WAIT.
REQ-015 WAIT SHALL go to RESP on first cycle with mem_busy=0, capturing mem_dout into the granted port's pn_rdata for reads.
REQ-016 WAIT SHALL count cycles; at count TIMEOUT with mem_busy still 1, go to RESP with err set.
REQ-017 RESP SHALL pulse granted pn_done for one cycle (pn_err=err), then return to IDLE; next grant earliest one cycle later.
REQ-018 Minimum request-to-done latency SHALL be 4 cycles (IDLE grant, ISSUE, GUARD, WAIT, done in RESP).
REQ-019 mem_byte_write SHALL be 0 whenever mem_read and mem_write are both 0; mem_read and mem_write SHALL never be high together.
REQ-020 Requests from the non-granted port SHALL be ignored until IDLE; a pn_req deasserted before grant SHALL be dropped silently.
REQ-021 Changes to a granted port's inputs after grant SHALL have no effect on the transaction.

Reset
REQ-022 On resetn=0 SHALL force state IDLE, all mem_* and pn_done/pn_err outputs 0, pn_rdata 0, timeout counter 0, last-grant pointer to port 1 (so port 0 wins first).
REQ-023 Reset mid-transaction SHALL abandon it without pn_done; after release, IDLE still waits for mem_busy=0 before any grant.

Configuration
REQ-024 With PSRAM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not granted last (round-robin).
REQ-025 Without PSRAM_ARB_RR_EN, port 0 SHALL always win simultaneous requests (fixed priority); last-grant pointer is not implemented.

Structure
REQ-026 Package psram_arb_pkg SHALL hold the FSM state encoding, port count constant (2) and port-id type.
REQ-027 Grant selection SHALL be a sub-module psram_arb_pick (inputs requests, last grant; output grant valid, id), containing the macro-dependent logic.

Verification
REQ-028 p0 write addr 0x00005, wdata 0xA5A5, byte=1, mem_busy high 3 cycles after GUARD -> one mem_write pulse with mem_addr=0x00005, mem_din=0xA5A5, mem_byte_write=1; p0_done at cycle 7 after grant, p0_err=0.
REQ-029 p1 read addr 0x3FFFFF, model returns 0x1234 at busy fall -> p1_done pulse, p1_rdata=0x1234, p0_done stays 0.
REQ-030 p0 and p1 request same cycle repeatedly, 4 transactions -> RR build: grants 0,1,0,1; fixed build: 0,0,0,0 while p0 keeps requesting.
REQ-031 mem_busy stuck high after ISSUE -> after TIMEOUT=64 WAIT cycles, pn_done with pn_err=1, FSM back in IDLE, no new grant while busy stays high.
REQ-032 mem_busy high from reset for 100 cycles with p0_req=1 -> no mem_read/mem_write until busy falls, then one grant.
REQ-033 resetn asserted during WAIT -> all outputs 0 asynchronously, no pn_done emitted; after release, pending p1_req serviced normally.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types for the two-port PSRAM arbiter: FSM encoding, port count, port id.
package psram_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester and memory-side signal bundle for psram_arbiter.
// slave = arbiter view, master = requesters plus memory device view.
interface psram_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);

  logic              p0_req;
  logic              p0_write;
  logic              p0_byte;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_done;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_write;
  logic              p1_byte;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_done;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic              mem_byte_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_busy;

  modport slave (
    input  p0_req, p0_write, p0_byte, p0_addr, p0_wdata,
    input  p1_req, p1_write, p1_byte, p1_addr, p1_wdata,
    input  mem_dout, mem_busy,
    output p0_done, p0_err, p0_rdata,
    output p1_done, p1_err, p1_rdata,
    output mem_read, mem_write, mem_byte_write, mem_addr, mem_din
  );

  modport master (
    output p0_req, p0_write, p0_byte, p0_addr, p0_wdata,
    output p1_req, p1_write, p1_byte, p1_addr, p1_wdata,
    output mem_dout, mem_busy,
    input  p0_done, p0_err, p0_rdata,
    input  p1_done, p1_err, p1_rdata,
    input  mem_read, mem_write, mem_byte_write, mem_addr, mem_din
  );

endinterface

// File: rtl/psram_arb_pick.sv
// Grant selection between the two requesters.
// PSRAM_ARB_RR_EN: round-robin on contention; otherwise port 0 has fixed priority.
module psram_arb_pick
  import psram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_id_t             last,
  output logic                 valid,
  output port_id_t             id
);

  assign valid = |req;

`ifdef PSRAM_ARB_RR_EN
  always_comb begin
    if (&req) id = ~last;
    else      id = req[0] ? port_id_t'(0) : port_id_t'(1);
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  assign id = req[0] ? port_id_t'(0) : port_id_t'(1);
`endif

endmodule

// File: rtl/psram_arbiter.sv
// Two-port PSRAM access arbiter: grant, one-cycle issue, guard, busy wait with timeout, done.
// Define PSRAM_ARB_RR_EN for round-robin arbitration (default build is fixed priority).
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            resetn,
  psram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  port_id_t            gnt_id;
  logic                gnt_write;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic [CNT_W-1:0]    cnt;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                mem_byte_q;
  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] err_q;
  logic [DATA_W-1:0]   rdata_q [NUM_PORTS];

  logic                pick_valid;
  port_id_t            pick_id;
  port_id_t            pick_last;
  logic                grant;
  logic                sel_write;
  logic                sel_byte;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  psram_arb_pick u_pick (
    .req   ({bus.p1_req, bus.p0_req}),
    .last  (pick_last),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign grant = pick_valid && !bus.mem_busy;

`ifdef PSRAM_ARB_RR_EN
  port_id_t last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          last_q <= port_id_t'(1);
    else if (state == ST_IDLE && grant)   last_q <= pick_id;
  end

  assign pick_last = last_q;
`else
  assign pick_last = port_id_t'(1);
`endif

  always_comb begin
    if (pick_id == port_id_t'(1)) begin
      sel_write = bus.p1_write;
      sel_byte  = bus.p1_byte;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end else begin
      sel_write = bus.p0_write;
      sel_byte  = bus.p0_byte;
      sel_addr  = bus.p0_addr;
      sel_wdata = bus.p0_wdata;
    end
  end

  // Strobes and done/err default low each cycle, so every pulse is one cycle wide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      gnt_id      <= '0;
      gnt_write   <= 1'b0;
      gnt_addr    <= '0;
      gnt_wdata   <= '0;
      cnt         <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_byte_q  <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_byte_q  <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            gnt_id      <= pick_id;
            gnt_write   <= sel_write;
            gnt_addr    <= sel_addr;
            gnt_wdata   <= sel_wdata;
            mem_write_q <= sel_write;
            mem_read_q  <= !sel_write;
            mem_byte_q  <= sel_byte;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_GUARD;
        ST_GUARD: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.mem_busy) begin
            if (!gnt_write) rdata_q[gnt_id] <= bus.mem_dout;
            done_q[gnt_id] <= 1'b1;
            state          <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            done_q[gnt_id] <= 1'b1;
            err_q[gnt_id]  <= 1'b1;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_byte_write = mem_byte_q;
  assign bus.mem_addr       = gnt_addr;
  assign bus.mem_din        = gnt_wdata;
  assign bus.p0_done        = done_q[0];
  assign bus.p0_err         = err_q[0];
  assign bus.p0_rdata       = rdata_q[0];
  assign bus.p1_done        = done_q[1];
  assign bus.p1_err         = err_q[1];
  assign bus.p1_rdata       = rdata_q[1];

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter with a behavioural memory device and reference model.
// Expectations follow PSRAM_ARB_RR_EN when it is defined.
module tb_psram_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  psram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic          wr;
    logic          bw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    int unsigned   cyc;
  } op_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  op_t         ops[$];
  int          op_logged = 0;
  int          busy_len = 0;
  logic        busy_r = 1'b0;
  logic        hold_busy = 1'b0;
  logic [DW-1:0] mem_store [int];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_rdata [2];
  int          ref_last = 1;
  int          d0_cnt = 0, d1_cnt = 0, op_cycles = 0, rule_viol = 0;

  assign bus.mem_busy = busy_r | hold_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.p0_done) d0_cnt <= d0_cnt + 1;
    if (bus.p1_done) d1_cnt <= d1_cnt + 1;
    if (bus.mem_read || bus.mem_write) op_cycles <= op_cycles + 1;
    if ((bus.mem_read && bus.mem_write) ||
        (!bus.mem_read && !bus.mem_write && bus.mem_byte_write) ||
        (bus.p0_err && !bus.p0_done) || (bus.p1_err && !bus.p1_done))
      rule_viol <= rule_viol + 1;
  end

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return fill(a);
  endfunction

  function automatic logic [31:0] outs_or();
    return 32'({bus.mem_read, bus.mem_write, bus.mem_byte_write, |bus.mem_addr, |bus.mem_din,
                bus.p0_done, bus.p0_err, |bus.p0_rdata, bus.p1_done, bus.p1_err, |bus.p1_rdata});
  endfunction

  // Memory device: busy rises in the issue cycle and stays up through the guard
  // cycle plus busy_len wait cycles; read data appears as busy falls.
  initial begin
    op_t o;
    int  bl;
    bus.mem_dout = '0;
    mem_store[int'(22'h3FFFFF)] = 16'h1234;
    forever begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        o.wr = bus.mem_write; o.bw = bus.mem_byte_write;
        o.addr = bus.mem_addr; o.din = bus.mem_din; o.cyc = cyc;
        ops.push_back(o);
        op_logged++;
        bl = busy_len;
        busy_r = 1'b1;
        repeat (bl + 2) @(negedge clk);
        if (o.wr) mem_store[int'(o.addr)] = o.din;
        else bus.mem_dout = mem_store.exists(int'(o.addr)) ? mem_store[int'(o.addr)] : fill(o.addr);
        busy_r = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic rq, input logic wr, input logic bt,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (p == 0) begin
      bus.p0_req = rq; bus.p0_write = wr; bus.p0_byte = bt; bus.p0_addr = a; bus.p0_wdata = wd;
    end else begin
      bus.p1_req = rq; bus.p1_write = wr; bus.p1_byte = bt; bus.p1_addr = a; bus.p1_wdata = wd;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) bus.p0_req = 1'b0;
    else        bus.p1_req = 1'b0;
  endtask

  task automatic wait_op(input int limit, output bit ok, output op_t o);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      if (ops.size() > 0) begin
        o = ops.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int p, input int limit, output bit ok, output int unsigned dc);
    ok = 1'b0; dc = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if ((p == 0 && bus.p0_done) || (p == 1 && bus.p1_done)) begin
        ok = 1'b1; dc = cyc;
      end
    end
  endtask

  // One single-port transaction; optionally scrambles the port inputs once granted.
  task automatic txn(input int p, input logic wr, input logic bt, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input int bl, input bit scramble);
    bit ok_op, ok_done;
    op_t o;
    int unsigned dc;
    int other_before;
    busy_len = bl;
    drive_port(p, 1'b1, wr, bt, a, wd);
    wait_op(40, ok_op, o);
    check("op_seen", 32'(ok_op), 1);
    other_before = (p == 0) ? d1_cnt : d0_cnt;
    if (ok_op) begin
      check("op_kind", 32'({o.wr, o.bw}), 32'({wr, bt}));
      check("op_addr", 32'(o.addr), 32'(a));
      if (wr) check("op_din", 32'(o.din), 32'(wd));
    end
    if (scramble) drive_port(p, 1'b1, ~wr, ~bt, AW'($urandom), DW'($urandom));
    wait_done(p, bl + 30, ok_done, dc);
    drop_req(p);
    check("done_seen", 32'(ok_done), 1);
    if (ok_op && ok_done) check("done_latency", dc - o.cyc, 32'(3 + bl));
    if (ok_done) begin
      check("done_err", 32'(p == 0 ? bus.p0_err : bus.p1_err), 0);
      if (wr) ref_mem[int'(a)] = wd;
      else    exp_rdata[p] = ref_read(a);
      check("rdata", 32'(p == 0 ? bus.p0_rdata : bus.p1_rdata), 32'(exp_rdata[p]));
    end
    ref_last = p;
    #1;
    check("other_port_quiet", 32'(p == 0 ? d1_cnt : d0_cnt), 32'(other_before));
  endtask

  initial begin
    bit          ok;
    op_t         o;
    int unsigned dc;
    int          p, who, exp_who, seen, d1_before;
    logic        wr, bt;
    logic [AW-1:0] pool [4];
    logic [AW-1:0] a0, a1;

    ref_mem[int'(22'h3FFFFF)] = 16'h1234;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    resetn = 1'b0;
    drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_or(), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed write on port 0 with three busy wait cycles.
    txn(0, 1'b1, 1'b1, 22'h00005, 16'hA5A5, 3, 1'b0);

    // Directed read on port 1 at the top address.
    txn(1, 1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 2, 1'b0);
    check("p1_rdata_1234", 32'(bus.p1_rdata), 32'h1234);

    // Random single-port traffic over a small address pool; inputs scrambled after grant.
    for (int k = 0; k < 4; k++) pool[k] = AW'($urandom);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      p  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      bt = 1'($urandom_range(0, 1));
      txn(p, wr, bt, pool[$urandom_range(0, 3)], DW'($urandom), int'($urandom_range(0, 6)), 1'b1);
    end

    // Both ports requesting continuously for four transactions.
    busy_len = 1;
    a0 = 22'h000100; a1 = 22'h000200;
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 1'b0, a0, '0);
    drive_port(1, 1'b1, 1'b0, 1'b0, a1, '0);
    for (int t = 0; t < 4; t++) begin
      wait_op(30, ok, o);
      check("arb_op_seen", 32'(ok), 1);
      who = -1;
      for (int i = 0; i < 30 && who < 0; i++) begin
        @(negedge clk);
        if (bus.p0_done)      who = 0;
        else if (bus.p1_done) who = 1;
      end
      if (t == 3) begin
        drop_req(0);
        drop_req(1);
      end
`ifdef PSRAM_ARB_RR_EN
      exp_who = 1 - ref_last;
`else
      exp_who = 0;
`endif
      check("arb_grant", 32'(who), 32'(exp_who));
      if (ok) check("arb_addr", 32'(o.addr), 32'(exp_who == 1 ? a1 : a0));
      if (who >= 0) begin
        exp_rdata[who] = ref_read(who == 1 ? a1 : a0);
        check("arb_rdata", 32'(who == 1 ? bus.p1_rdata : bus.p0_rdata), 32'(exp_rdata[who]));
        ref_last = who;
      end
    end
    repeat (10) @(negedge clk);
    #1;
    check("arb_dropped_quiet", 32'(ops.size()), 0);

    // Busy stuck high after issue: timeout with error, then no grant while busy.
    busy_len = 0;
    drive_port(0, 1'b1, 1'b0, 1'b0, 22'h000321, '0);
    wait_op(30, ok, o);
    hold_busy = 1'b1;
    check("to_op_seen", 32'(ok), 1);
    wait_done(0, TO + 30, ok, dc);
    drop_req(0);
    check("to_done_seen", 32'(ok), 1);
    if (ok) begin
      check("to_latency", dc - o.cyc, 32'(2 + TO));
      check("to_err", 32'(bus.p0_err), 1);
      check("to_rdata_held", 32'(bus.p0_rdata), 32'(exp_rdata[0]));
    end
    ref_last = 0;
    drive_port(1, 1'b1, 1'b0, 1'b0, 22'h000777, '0);
    repeat (10) @(negedge clk);
    #1;
    check("to_busy_blocks_grant", 32'(ops.size()), 0);
    hold_busy = 1'b0;
    txn(1, 1'b0, 1'b0, 22'h000777, '0, 1, 1'b0);

    // Busy high straight out of reset holds off the grant.
    @(negedge clk);
    hold_busy = 1'b1;
    resetn = 1'b0;
    ref_last = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    @(negedge clk);
    resetn = 1'b1;
    drive_port(0, 1'b1, 1'b1, 1'b0, 22'h000ABC, 16'hBEEF);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) seen++;
    end
    check("busy_reset_no_op", 32'(seen), 0);
    hold_busy = 1'b0;
    txn(0, 1'b1, 1'b0, 22'h000ABC, 16'hBEEF, 2, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("busy_reset_single_grant", 32'(ops.size()), 0);

    // Reset during the wait phase abandons the transaction without a done pulse.
    busy_len = 20;
    drive_port(1, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, '0);
    wait_op(30, ok, o);
    check("rst_op_seen", 32'(ok), 1);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_outputs", outs_or(), 0);
    ref_last = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    d1_before = d1_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    txn(1, 1'b0, 1'b0, 22'h3FFFFF, '0, 2, 1'b0);
    check("rst_single_done", 32'(d1_cnt), 32'(d1_before + 1));

    repeat (3) @(negedge clk);
    #1;
    check("strobe_rules", 32'(rule_viol), 0);
    check("one_cycle_strobes", 32'(op_cycles), 32'(op_logged));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
